// File: rtl/sayac_mul_pkg.sv
// Shared types and constants for the SAYAC sequential Booth multiplier.
//   state_t : multiplier FSM states (IDLE, RUN, DONE)
//   ADD/SUB : Booth select codes keyed on {Q[0], q_1}
package sayac_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/adder_subtractor.sv
// SAYAC adder/subtractor: sum_c = a + b when subsel=0, a - b when subsel=1.
// Ports:
//   a, b    [size-1:0] operands
//   subsel  1          subtract select
//   sum_c   [size-1:0] combinational result; carry-out is discarded
module adder_subtractor #(
    parameter int unsigned size = 17
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            subsel,
    output logic [size-1:0] sum_c
);

    // Two's-complement subtract: invert b and inject the carry-in.
    always_comb begin
        sum_c = a + (b ^ {size{subsel}}) + size'(subsel);
    end

endmodule

// File: rtl/sayac_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed size x size -> signed 2*size.
// One Booth step per cycle in RUN; result registered on the RUN->DONE edge.
// Optional feature macro: SAYAC_MUL_OVF_EN adds the registered ovf output.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   start    request, sampled only in IDLE
//   a, b     [size-1:0] signed multiplicand / multiplier
//   busy     high whenever not IDLE
//   done     one-cycle pulse while in DONE
//   product  [2*size-1:0] signed result, held until the next result
//   ovf      (SAYAC_MUL_OVF_EN only) result does not fit in size bits
module sayac_booth_multiplier
    import sayac_mul_pkg::*;
#(
    parameter int unsigned size = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [size-1:0]     a,
    input  logic [size-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*size-1:0]   product
`ifdef SAYAC_MUL_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int unsigned AW = size + 1;
    localparam int unsigned CW = $clog2(size + 1);
    localparam int unsigned PW = 2 * size;

    state_t          state, next_state;
    logic [AW-1:0]   m_q, acc_q;
    logic [size-1:0] q_q;
    logic            q1_q;
    logic [CW-1:0]   cnt_q;

    logic [AW-1:0]   addend_c, sum_c;
    logic            subsel_c;
    logic [AW-1:0]   acc_shift_c;
    logic [size-1:0] q_shift_c;
    logic [PW-1:0]   prod_next_c;
    logic            last_step_c;
    logic            busy_d, done_d;

    // Booth decode: add M, subtract M, or pass ACC through (+0).
    always_comb begin
        addend_c = '0;
        subsel_c = 1'b0;
        case ({q_q[0], q1_q})
            ADD: addend_c = m_q;
            SUB: begin
                addend_c = m_q;
                subsel_c = 1'b1;
            end
            default: ;
        endcase
    end

    adder_subtractor #(
        .size (AW)
    ) u_addsub (
        .a      (acc_q),
        .b      (addend_c),
        .subsel (subsel_c),
        .sum_c  (sum_c)
    );

    // Arithmetic right shift of {sum, Q, q_1}; sum MSB is replicated.
    always_comb begin
        acc_shift_c = {sum_c[AW-1], sum_c[AW-1:1]};
        q_shift_c   = {sum_c[0], q_q[size-1:1]};
        prod_next_c = {acc_shift_c[size-1:0], q_shift_c};
        last_step_c = (state == RUN) && (cnt_q == CW'(size - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (cnt_q == CW'(size - 1)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (next_state != IDLE) busy_d = 1'b1;
        if (next_state == DONE) done_d = 1'b1;
    end

    // Handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Booth datapath: load on accept, one shift-step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= {a[size-1], a};
                        acc_q <= '0;
                        q_q   <= b;
                        q1_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_shift_c;
                    q_q   <= q_shift_c;
                    q1_q  <= q_q[0];
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result register, written only on the final Booth step.
    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
        end else if (last_step_c) begin
            product <= prod_next_c;
        end
    end

`ifdef SAYAC_MUL_OVF_EN
    logic ovf_c;

    // Fits in size bits only if the top size+1 result bits are all equal.
    always_comb begin
        ovf_c = ~((&prod_next_c[PW-1:size-1]) | ~(|prod_next_c[PW-1:size-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last_step_c) begin
            ovf <= ovf_c;
        end
    end
`endif

endmodule
